univ_shift_engine: RTL and testbench

UNIV_SHIFT_ENGINE -- requirements
Module: univ_shift_engine

---
 rtl/univ_shift_pkg.sv | 25 ++
 rtl/univ_shift_engine_shift_step.sv | 46 ++++
 rtl/univ_shift_engine.sv | 113 +++++++++++
 tb/tb_univ_shift_engine.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/univ_shift_pkg.sv
// Shared op codes, FSM state encodings and op classification for the universal shift engine.
package univ_shift_pkg;

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_SRL  = 3'b001,
    OP_SLL  = 3'b010,
    OP_LOAD = 3'b011,
    OP_ROR  = 3'b100,
    OP_ROL  = 3'b101,
    OP_ASR  = 3'b110,
    OP_CLR  = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  function automatic logic is_shift_op(input op_e op);
    return (op == OP_SRL) || (op == OP_SLL) || (op == OP_ROR) ||
           (op == OP_ROL) || (op == OP_ASR);
  endfunction

endpackage

// File: rtl/univ_shift_engine_shift_step.sv
// Combinational single-step next value for the shift/rotate ops; other ops pass q through.
module shift_step
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] q,
  input  logic             s_left,
  input  logic             s_right,
  output logic [WIDTH-1:0] q_next,
  output logic             ser_next
);

  always_comb begin
    q_next   = q;
    ser_next = 1'b0;
    case (op)
      OP_SRL: begin
        q_next   = {s_left, q[WIDTH-1:1]};
        ser_next = q[0];
      end
      OP_SLL: begin
        q_next   = {q[WIDTH-2:0], s_right};
        ser_next = q[WIDTH-1];
      end
      OP_ROR: begin
        q_next   = {q[0], q[WIDTH-1:1]};
        ser_next = q[0];
      end
      OP_ROL: begin
        q_next   = {q[WIDTH-2:0], q[WIDTH-1]};
        ser_next = q[WIDTH-1];
      end
      OP_ASR: begin
        q_next   = {q[WIDTH-1], q[WIDTH-1:1]};
        ser_next = q[0];
      end
      default: begin
        q_next   = q;
        ser_next = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/univ_shift_engine.sv
// Universal shift register engine: accepts one command at a time and runs multi-step
// shifts/rotates one bit per clock, pulsing done after the last step.
module univ_shift_engine
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] count,
  input  logic [WIDTH-1:0] data_in,
  input  logic             s_left,
  input  logic             s_right,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             ser_q, ser_d;
  logic             done_q, done_d;

  op_e              op_in;
  op_e              step_op;
  logic             accept;
  logic [WIDTH-1:0] step_q;
  logic             step_ser;

  assign op_in     = op_e'(op);
  assign busy      = (state_q == ST_SHIFT);
  assign cmd_ready = !busy;
  assign accept    = cmd_valid && cmd_ready;
  assign step_op   = busy ? op_q : op_in;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op      (step_op),
    .q       (q_q),
    .s_left  (s_left),
    .s_right (s_right),
    .q_next  (step_q),
    .ser_next(step_ser)
  );

  // rem_q holds the steps still to run after the current edge while in SHIFT.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rem_d   = rem_q;
    q_d     = q_q;
    ser_d   = ser_q;
    done_d  = 1'b0;
    if (state_q == ST_SHIFT) begin
      q_d   = step_q;
      ser_d = step_ser;
      rem_d = rem_q - CNT_W'(1);
      if (rem_q == CNT_W'(1)) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end else if (accept) begin
      op_d = op_in;
      if (is_shift_op(op_in)) begin
        if (count == '0) begin
          done_d = 1'b1;
        end else begin
          q_d   = step_q;
          ser_d = step_ser;
          if (count == CNT_W'(1)) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_SHIFT;
            rem_d   = count - CNT_W'(1);
          end
        end
      end else begin
        done_d = 1'b1;
        if (op_in == OP_LOAD) q_d = data_in;
        else if (op_in == OP_CLR) q_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_HOLD;
      rem_q   <= '0;
      q_q     <= '0;
      ser_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      ser_q   <= ser_d;
      done_q  <= done_d;
    end
  end

  assign q       = q_q;
  assign ser_out = ser_q;
  assign done    = done_q;

endmodule

// File: tb/tb_univ_shift_engine.sv
// Table-driven bench for univ_shift_engine with a done-driven scoreboard of expected q/ser_out.
module tb_univ_shift_engine;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] op;
  logic [3:0] count;
  logic [7:0] data_in;
  logic       s_left;
  logic       s_right;
  logic [7:0] q;
  logic       ser_out;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] op;
    logic [3:0] cnt;
    logic [7:0] data;
    logic       sl;
    logic       sr;
    logic [7:0] exp_q;
    logic       exp_ser;
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic       ser;
  } sb_t;

  vec_t vecs[16];
  sb_t  sb_q[$];

  univ_shift_engine #(.WIDTH(8), .CNT_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .op       (op),
    .count    (count),
    .data_in  (data_in),
    .s_left   (s_left),
    .s_right  (s_right),
    .q        (q),
    .ser_out  (ser_out),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every done pulse retires the oldest expected result.
  always @(negedge clk) begin
    sb_t e;
    if (!reset && done) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got done=1 expected no pending command at %0t", $time);
      end else begin
        e = sb_q.pop_front();
        check("sb_q", 32'(q), 32'(e.q));
        check("sb_ser", 32'(ser_out), 32'(e.ser));
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] o, input logic [3:0] c, input logic [7:0] d,
                               input logic sl, input logic sr);
    @(negedge clk);
    op = o; count = c; data_in = d; s_left = sl; s_right = sr;
    cmd_valid = 1'b1;
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic waitDone(output int lat, output int busy_n);
    lat = 0;
    busy_n = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) busy_n++;
    end while (!done && lat < 40);
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: got no done expected done within 40 cycles");
    end
  endtask

  function automatic bit bench_is_shift(input logic [2:0] o);
    return o == 3'd1 || o == 3'd2 || o == 3'd4 || o == 3'd5 || o == 3'd6;
  endfunction

  initial begin
    int lat, busy_n, exp_lat, exp_busy;
    vecs[0]  = '{3'b011, 4'd0, 8'h81, 1'b0, 1'b0, 8'h81, 1'b0};
    vecs[1]  = '{3'b101, 4'd3, 8'h00, 1'b0, 1'b0, 8'h0C, 1'b0};
    vecs[2]  = '{3'b011, 4'd0, 8'h90, 1'b0, 1'b0, 8'h90, 1'b0};
    vecs[3]  = '{3'b110, 4'd2, 8'h00, 1'b0, 1'b0, 8'hE4, 1'b0};
    vecs[4]  = '{3'b111, 4'd0, 8'h77, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[5]  = '{3'b001, 4'd4, 8'h00, 1'b1, 1'b0, 8'hF0, 1'b0};
    vecs[6]  = '{3'b011, 4'd0, 8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0};
    vecs[7]  = '{3'b010, 4'd3, 8'h00, 1'b0, 1'b0, 8'hF8, 1'b1};
    vecs[8]  = '{3'b100, 4'd1, 8'h00, 1'b0, 1'b0, 8'h7C, 1'b0};
    vecs[9]  = '{3'b000, 4'd5, 8'h55, 1'b1, 1'b1, 8'h7C, 1'b0};
    vecs[10] = '{3'b010, 4'd0, 8'h00, 1'b1, 1'b1, 8'h7C, 1'b0};
    vecs[11] = '{3'b101, 4'd2, 8'h00, 1'b0, 1'b0, 8'hF1, 1'b1};
    vecs[12] = '{3'b110, 4'd1, 8'h00, 1'b0, 1'b0, 8'hF8, 1'b1};
    vecs[13] = '{3'b001, 4'd2, 8'h00, 1'b0, 1'b1, 8'h3E, 1'b0};
    vecs[14] = '{3'b010, 4'd4, 8'h00, 1'b0, 1'b1, 8'hEF, 1'b1};
    vecs[15] = '{3'b011, 4'd0, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b1};

    reset = 1'b1; cmd_valid = 1'b0; op = '0; count = '0; data_in = '0;
    s_left = 1'b0; s_right = 1'b0;
    #1;
    check("reset_q", 32'(q), 32'd0);
    check("reset_ser", 32'(ser_out), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].op, vecs[i].cnt, vecs[i].data, vecs[i].sl, vecs[i].sr);
      sb_q.push_back('{vecs[i].exp_q, vecs[i].exp_ser});
      waitDone(lat, busy_n);
      exp_lat  = (bench_is_shift(vecs[i].op) && vecs[i].cnt > 1) ? int'(vecs[i].cnt) : 1;
      exp_busy = exp_lat - 1;
      check($sformatf("latency_%0d", i), 32'(lat), 32'(exp_lat));
      check($sformatf("busy_cycles_%0d", i), 32'(busy_n), 32'(exp_busy));
    end

    // SRL by 8 on 0xA5 with a LOAD held on cmd_valid throughout; only the done-cycle LOAD lands.
    applyStimulus(3'b001, 4'd8, 8'h00, 1'b0, 1'b0);
    sb_q.push_back('{8'h00, 1'b1});
    op = 3'b011; data_in = 8'h3C; cmd_valid = 1'b1;
    @(negedge clk);
    check("ready_while_busy", 32'(cmd_ready), 32'd0);
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("srl8_latency", 32'(lat), 32'd8);
    check("ready_in_done_cycle", 32'(cmd_ready), 32'd1);
    sb_q.push_back('{8'h3C, 1'b1});
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    waitDone(lat, busy_n);
    check("load_after_done_latency", 32'(lat), 32'd1);

    // Reset two cycles into an SRL by 5 aborts it silently.
    applyStimulus(3'b001, 4'd5, 8'h00, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_q", 32'(q), 32'd0);
    check("abort_ser", 32'(ser_out), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("no_done_after_abort", 32'(done), 32'd0);
    applyStimulus(3'b010, 4'd0, 8'h00, 1'b0, 1'b1);
    sb_q.push_back('{8'h00, 1'b0});
    waitDone(lat, busy_n);
    check("sll0_latency", 32'(lat), 32'd1);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
